// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor controller.
//   - state_e   : FSM state encoding (IDLE, RUN, DONE)
//   - NIBBLE_W  : width of the shared adder slice
//   - idx_width : width of the nibble index counter for a given nibble count
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a counter that walks nibbles 0 .. nibbles-1.
    function automatic int idx_width(input int nibbles);
        return $clog2(nibbles);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder slice, shared by the nibble-serial controller.
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry in
//   sum   : 4-bit sum
//   cout  : carry out of the top bit
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder/subtractor. One shared 4-bit ripple-carry slice is
// stepped over WIDTH/4 cycles, LSB nibble first, with the carry registered
// between passes. Subtraction is A + ~B + 1 (carry register seeded with 1).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//   a, b, sub             : operands and op select (0 = A+B, 1 = A-B)
//   out_valid / out_ready : result handshake (out_valid only in DONE)
//   result, cout, ovf     : sum/difference, carry out (sub: 1 = no borrow),
//                           signed overflow
//   busy                  : high in RUN or DONE
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    // Operands and result viewed as arrays of nibbles so the active nibble
    // is selected by plain indexing with the pass counter.
    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    nib_vec_t         a_q, a_d;
    nib_vec_t         b_eff_q, b_eff_d;
    nib_vec_t         result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    ripple_carry_adder u_slice (
        .a    (a_q[idx_q]),
        .b    (b_eff_q[idx_q]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_eff_d  = b_eff_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_eff_d = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                result_d[idx_q] = slice_sum;
                carry_d         = slice_cout;
                idx_d           = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    // Same-signed operands producing a differently-signed
                    // result; slice_sum's top bit is the final result MSB.
                    ovf_d   = (a_q[NIBBLES-1][NIBBLE_W-1] == b_eff_q[NIBBLES-1][NIBBLE_W-1])
                           && (slice_sum[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on the
    // accept edge before RUN reads them, so a reset would only cost logic.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_eff_q <= b_eff_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

    localparam int W       = 16;
    localparam int NIBBLES = W / 4;
    localparam int BOUND   = 20;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Reference: plain W+1-bit arithmetic on sign-extended operands.
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
        exp_t         e;
        logic [W:0]   u;
        logic [W:0]   s;
        logic [W:0]   xa;
        logic [W:0]   xb;
        u = si ? ({1'b0, ai} - {1'b0, bi}) : ({1'b0, ai} + {1'b0, bi});
        xa = {ai[W-1], ai};
        xb = {bi[W-1], bi};
        s = si ? (xa - xb) : (xa + xb);
        e.result = u[W-1:0];
        e.cout   = si ? ~u[W] : u[W];
        e.ovf    = s[W] ^ s[W-1];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operand set and waits (bounded) for the accept edge.
    task automatic accept_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                             output int waits, output bit ok);
        a        = ai;
        b        = bi;
        sub      = si;
        in_valid = 1'b1;
        ok       = 1'b0;
        waits    = 0;
        while (!ok && waits < BOUND) begin
            if (in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
            end else begin
                tick();
                waits++;
            end
        end
        in_valid = 1'b0;
        sb.push_back(model(ai, bi, si));
    endtask

    // Counts edges until out_valid is seen, bounded.
    task automatic wait_out_valid(output int n, output bit ok);
        n = 0;
        while (out_valid !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %h expected 0000", result); end
        checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
    endtask

    task automatic test_add();
        logic [W-1:0] ta, tb_v;
        int   waits, lat;
        bit   ok, vok;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin ta = 16'h1234; tb_v = 16'h0FED; end
                1:       begin ta = 16'hFFFF; tb_v = 16'h0001; end
                2:       begin ta = 16'h7FFF; tb_v = 16'h0001; end
                default: begin ta = 16'h8000; tb_v = 16'h8000; end
            endcase
            accept_op(ta, tb_v, 1'b0, waits, ok);
            checks++; if (!ok) begin failures++; $display("FAIL add_accept[%0d]: got no accept expected accept", i); end
            wait_out_valid(lat, vok);
            checks++; if (!vok || lat != NIBBLES) begin failures++; $display("FAIL add_latency[%0d]: got %0d valid=%b expected %0d", i, lat, vok, NIBBLES); end
            e = sb.pop_front();
            checks++; if (result !== e.result) begin failures++; $display("FAIL add_result[%0d]: got %h expected %h", i, result, e.result); end
            checks++; if (cout !== e.cout) begin failures++; $display("FAIL add_cout[%0d]: got %b expected %b", i, cout, e.cout); end
            checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL add_ovf[%0d]: got %b expected %b", i, ovf, e.ovf); end
            tick();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL add_handshake[%0d]: got valid=%b ready=%b expected 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] ta, tb_v;
        int   waits, lat;
        bit   ok, vok;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin ta = 16'h0005; tb_v = 16'h0007; end
                1:       begin ta = 16'h8000; tb_v = 16'h0001; end
                default: begin ta = 16'h1234; tb_v = 16'h1234; end
            endcase
            accept_op(ta, tb_v, 1'b1, waits, ok);
            checks++; if (!ok) begin failures++; $display("FAIL sub_accept[%0d]: got no accept expected accept", i); end
            wait_out_valid(lat, vok);
            checks++; if (!vok || lat != NIBBLES) begin failures++; $display("FAIL sub_latency[%0d]: got %0d valid=%b expected %0d", i, lat, vok, NIBBLES); end
            e = sb.pop_front();
            checks++; if (result !== e.result) begin failures++; $display("FAIL sub_result[%0d]: got %h expected %h", i, result, e.result); end
            checks++; if (cout !== e.cout) begin failures++; $display("FAIL sub_cout[%0d]: got %b expected %b", i, cout, e.cout); end
            checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL sub_ovf[%0d]: got %b expected %b", i, ovf, e.ovf); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int   waits, lat;
        bit   ok, vok;
        exp_t e;
        out_ready = 1'b0;
        accept_op(16'h8000, 16'h8000, 1'b0, waits, ok);
        wait_out_valid(lat, vok);
        checks++; if (!vok) begin failures++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            // A new operand set offered while DONE must be ignored.
            a        = 16'(i * 16'h1111);
            b        = 16'h0F0F;
            sub      = 1'(i);
            in_valid = 1'b1;
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_flags[%0d]: got valid=%b ready=%b expected 1 0", i, out_valid, in_ready); end
            checks++; if (result !== e.result || cout !== e.cout || ovf !== e.ovf) begin failures++; $display("FAIL bp_hold_data[%0d]: got %h/%b/%b expected %h/%b/%b", i, result, cout, ovf, e.result, e.cout, e.ovf); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_release: got valid=%b ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy); end
        accept_op(16'h00FF, 16'h0001, 1'b0, waits, ok);
        checks++; if (!ok || waits != 0) begin failures++; $display("FAIL bp_next_accept: got waits=%0d ok=%b expected 0 1", waits, ok); end
        wait_out_valid(lat, vok);
        e = sb.pop_front();
        checks++; if (!vok || result !== e.result || cout !== e.cout || ovf !== e.ovf) begin failures++; $display("FAIL bp_next_result: got %h/%b/%b expected %h/%b/%b", result, cout, ovf, e.result, e.cout, e.ovf); end
        tick();
    endtask

    task automatic test_operand_change();
        int   waits, n;
        bit   ok;
        exp_t e;
        accept_op(16'h89AB, 16'h7654, 1'b1, waits, ok);
        n = 0;
        while (out_valid !== 1'b1 && n < BOUND) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            sub      = 1'($urandom);
            in_valid = 1'b1;
            checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL opchg_run_flags[%0d]: got ready=%b busy=%b expected 0 1", n, in_ready, busy); end
            tick();
            n++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (n != NIBBLES) begin failures++; $display("FAIL opchg_latency: got %0d expected %0d", n, NIBBLES); end
        checks++; if (result !== e.result || cout !== e.cout || ovf !== e.ovf) begin failures++; $display("FAIL opchg_result: got %h/%b/%b expected %h/%b/%b", result, cout, ovf, e.result, e.cout, e.ovf); end
        tick();
    endtask

    task automatic test_mid_run_reset();
        int   waits, lat;
        bit   ok, vok;
        exp_t e;
        accept_op(16'hABCD, 16'h1111, 1'b0, waits, ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_run_flags: got ready=%b valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy); end
        checks++; if (result !== '0) begin failures++; $display("FAIL rst_run_result: got %h expected 0000", result); end
        accept_op(16'h0F0F, 16'h00F1, 1'b0, waits, ok);
        wait_out_valid(lat, vok);
        e = sb.pop_front();
        checks++; if (!vok || lat != NIBBLES) begin failures++; $display("FAIL rst_fresh_latency: got %0d valid=%b expected %0d", lat, vok, NIBBLES); end
        checks++; if (result !== e.result || cout !== e.cout || ovf !== e.ovf) begin failures++; $display("FAIL rst_fresh_result: got %h/%b/%b expected %h/%b/%b", result, cout, ovf, e.result, e.cout, e.ovf); end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_operand_change();
        test_mid_run_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
